keypad_scan_debounce: RTL and testbench

- Upstream front-end for the digital lock's digit-entry path: drives the 3x3 keypad rows, samples the columns, debounces, and encodes one key.
- Produces the `button` code and `bstate` held-flag consumed by the length checker, valid checker and controller FSM.
- Adds a one-cycle `key_valid` press strobe, so consumers no longer edge-detect `bstate`.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/col_sync.sv | 29 ++
 rtl/keypad_scan_debounce.sv | 149 ++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan/debounce front-end.
// Row/column indices are 0-based; key codes are 1..9 with 0 meaning "none".
package keypad_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_NONE = 4'd0;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    endfunction

    // True only for a single low column; multi-key patterns are rejected.
    function automatic logic single_low(input logic [NUM_COLS-1:0] cols);
        return (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
    endfunction

    function automatic logic [1:0] low_col(input logic [NUM_COLS-1:0] cols);
        case (cols)
            3'b101:  return 2'd1;
            3'b011:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] next_row(input logic [1:0] row);
        return (row == 2'(NUM_ROWS - 1)) ? 2'd0 : row + 2'd1;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Multi-bit 2-FF synchronizer for the asynchronous keypad column inputs.
// Resets to all-1, the idle (pulled-up, no key) level.
module col_sync #(
    parameter int WIDTH = 3
) (
    input  logic             hwclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments make r_meta -> r_sync a true two-stage
    // pipeline; blocking ones would collapse it into a single flop.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {WIDTH{1'b1}};
            r_sync <= {WIDTH{1'b1}};
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 3x3 keypad row scanner with press/release debounce and single-key encoding.
// Emits the held key code, a debounced held flag and a one-cycle press strobe.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL        = 1200,
    parameter int DEBOUNCE_SAMPLES = 100
) (
    input  logic       hwclk,
    input  logic       rst_n,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_valid
);

    localparam int DW_W  = $clog2(ROW_DWELL);
    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(ROW_DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [NUM_COLS-1:0] w_col_raw;
    logic [NUM_COLS-1:0] w_col_s;
    logic                w_sample;
    logic [CNT_W-1:0]    w_match_inc;
    logic [CNT_W-1:0]    w_release_inc;
    logic [3:0]          w_scan_code;

    logic [DW_W-1:0]     r_dwell;
    state_t              r_state;
    logic [1:0]          r_row;
    logic [3:0]          r_cand_code;
    logic [NUM_COLS-1:0] r_cand_pat;
    logic [CNT_W-1:0]    r_match;
    logic [CNT_W-1:0]    r_release;
    logic [3:0]          r_button;
    logic                r_bstate;
    logic                r_key_valid;

    assign w_col_raw = {keypad_c3, keypad_c2, keypad_c1};

    col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
        .hwclk   (hwclk),
        .rst_n   (rst_n),
        .i_async (w_col_raw),
        .o_sync  (w_col_s)
    );

    assign w_sample      = (r_dwell == DWELL_LAST);
    assign w_match_inc   = r_match + CNT_ONE;
    assign w_release_inc = r_release + CNT_ONE;
    assign w_scan_code   = key_code(r_row, low_col(w_col_s));

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_row       <= 2'd0;
            r_cand_code <= KEY_NONE;
            r_cand_pat  <= '1;
            r_match     <= '0;
            r_release   <= '0;
            r_button    <= KEY_NONE;
            r_bstate    <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (single_low(w_col_s)) begin
                            // Capturing sample counts as the first match; row stays put.
                            r_cand_code <= w_scan_code;
                            r_cand_pat  <= w_col_s;
                            r_match     <= CNT_ONE;
                            if (DEBOUNCE_SAMPLES == 1) begin
                                r_button    <= w_scan_code;
                                r_bstate    <= 1'b1;
                                r_key_valid <= 1'b1;
                                r_release   <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_row <= next_row(r_row);
                        end
                    end
                    DEBOUNCE: begin
                        if (w_col_s == r_cand_pat) begin
                            r_match <= w_match_inc;
                            if (w_match_inc == CNT_DONE) begin
                                r_button    <= r_cand_code;
                                r_bstate    <= 1'b1;
                                r_key_valid <= 1'b1;
                                r_release   <= '0;
                                r_state     <= HELD;
                            end
                        end else begin
                            r_state <= SCAN;
                            r_row   <= next_row(r_row);
                        end
                    end
                    HELD: begin
                        // Any low column, including extra keys, keeps the key held.
                        if (w_col_s == '1) begin
                            if (w_release_inc == CNT_DONE) begin
                                r_bstate  <= 1'b0;
                                r_release <= '0;
                                r_state   <= SCAN;
                                r_row     <= next_row(r_row);
                            end else begin
                                r_release <= w_release_inc;
                            end
                        end else begin
                            r_release <= '0;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign keypad_r1 = (r_row != 2'd0);
    assign keypad_r2 = (r_row != 2'd1);
    assign keypad_r3 = (r_row != 2'd2);

    assign button    = r_button;
    assign bstate    = r_bstate;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce with a behavioural 3x3 keypad model.
// Stimulus pushes expected key codes; a negedge monitor pops them on key_valid.
module tb_keypad_scan_debounce;

    logic       hwclk = 1'b0;
    logic       rst_n;
    logic       r1, r2, r3;
    logic       c1, c2, c3;
    logic [3:0] button;
    logic       bstate;
    logic       key_valid;

    logic [8:0] pressed;
    logic       glitch_c2;
    logic [3:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 hwclk = ~hwclk;

    // Key index 3r+c; a column reads low when a pressed key sits on the driven row.
    assign c1 = ~((pressed[0] & ~r1) | (pressed[3] & ~r2) | (pressed[6] & ~r3));
    assign c2 = ~((pressed[1] & ~r1) | (pressed[4] & ~r2) | (pressed[7] & ~r3) | glitch_c2);
    assign c3 = ~((pressed[2] & ~r1) | (pressed[5] & ~r2) | (pressed[8] & ~r3));

    keypad_scan_debounce #(.ROW_DWELL(4), .DEBOUNCE_SAMPLES(3)) dut (
        .hwclk     (hwclk),
        .rst_n     (rst_n),
        .keypad_r1 (r1),
        .keypad_r2 (r2),
        .keypad_r3 (r3),
        .keypad_c1 (c1),
        .keypad_c2 (c2),
        .keypad_c3 (c3),
        .button    (button),
        .bstate    (bstate),
        .key_valid (key_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic wait_bstate(input logic v, input int budget, input string name);
        for (int i = 0; i < budget && bstate !== v; i++) tick(1);
        check(name, bstate, v);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 0);
    endtask

    // Leaves the bench at #1 after the edge on which row r1 became driven.
    task automatic sync_to_r1(input string name);
        int i;
        for (i = 0; i < 40 && r1 !== 1'b1; i++) tick(1);
        for (i = 0; i < 40 && r1 !== 1'b0; i++) tick(1);
        check(name, r1, 1'b0);
    endtask

    // Monitor: pops one expectation per key_valid and checks strobe rules.
    logic prev_bstate = 1'b0;
    logic prev_kv     = 1'b0;
    always @(negedge hwclk) begin
        if (rst_n) begin
            check("row_one_low", $countones(~{r3, r2, r1}), 1);
            if (key_valid) begin
                check("kv_with_bstate", bstate, 1'b1);
                check("kv_while_held", prev_bstate, 1'b0);
                check("kv_double", prev_kv, 1'b0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL kv_unexpected: got key_valid with button=%0d expected none (t=%0t)",
                             button, $time);
                end else begin
                    check("kv_button", button, exp_q.pop_front());
                end
            end
            prev_bstate = bstate;
            prev_kv     = key_valid;
        end else begin
            prev_bstate = 1'b0;
            prev_kv     = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seen;
        logic       any_bstate;

        pressed   = '0;
        glitch_c2 = 1'b0;
        rst_n     = 1'b0;
        #12;
        check("rst_button", button, 0);
        check("rst_bstate", bstate, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_rows", {r3, r2, r1}, 3'b110);
        @(negedge hwclk) rst_n = 1'b1;
        tick(10);

        // Clean press of r2/c3 -> code 6, held 200 cycles, then released.
        exp_q.push_back(4'd6);
        pressed[5] = 1'b1;
        wait_bstate(1'b1, 100, "s1_accept");
        drain("s1_kv", 10);
        tick(200);
        check("s1_held", bstate, 1'b1);
        pressed[5] = 1'b0;
        tick(9);
        check("s1_release_not_early", bstate, 1'b1);
        wait_bstate(1'b0, 6, "s1_release");
        check("s1_button_kept", button, 6);
        tick(20);
        check("s1_button_idle", button, 6);

        // Bounce on r1/c1: captured, one high sample rejects it, then steady.
        sync_to_r1("s2_sync");
        exp_q.push_back(4'd1);
        pressed[0] = 1'b1;
        tick(4);
        check("s2_captured_row", r1, 1'b0);
        pressed[0] = 1'b0;
        tick(4);
        pressed[0] = 1'b1;
        check("s2_reject_row", {r3, r2, r1}, 3'b101);
        check("s2_no_accept", bstate, 1'b0);
        wait_bstate(1'b1, 100, "s2_accept");
        drain("s2_kv", 10);
        check("s2_button", button, 1);
        pressed[0] = 1'b0;
        wait_bstate(1'b0, 40, "s2_release");

        // Two keys on the same row: never accepted, rows keep rotating.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        seen       = '0;
        any_bstate = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            seen       = seen | ~{r3, r2, r1};
            any_bstate = any_bstate | bstate;
        end
        check("s3_no_bstate", any_bstate, 1'b0);
        check("s3_rows_rotate", seen, 3'b111);
        check("s3_button", button, 1);
        pressed = '0;
        tick(10);

        // Hold r3/c2 (code 8), add r3/c3: ignored until both are released.
        exp_q.push_back(4'd8);
        pressed[7] = 1'b1;
        wait_bstate(1'b1, 100, "s4_accept");
        drain("s4_kv", 10);
        check("s4_button", button, 8);
        pressed[8] = 1'b1;
        tick(60);
        check("s4_both_held", bstate, 1'b1);
        pressed[7] = 1'b0;
        tick(30);
        check("s4_one_still_held", bstate, 1'b1);
        check("s4_button_kept", button, 8);
        pressed[8] = 1'b0;
        wait_bstate(1'b0, 40, "s4_release");

        // Asynchronous reset while HELD, key re-detected afterwards.
        exp_q.push_back(4'd8);
        pressed[7] = 1'b1;
        wait_bstate(1'b1, 100, "s5_accept");
        drain("s5_kv", 10);
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_button", button, 0);
        check("s5_rst_bstate", bstate, 0);
        check("s5_rst_rows", {r3, r2, r1}, 3'b110);
        check("s5_rst_kv", key_valid, 0);
        tick(3);
        @(negedge hwclk) rst_n = 1'b1;
        exp_q.push_back(4'd8);
        wait_bstate(1'b1, 100, "s5_reaccept");
        drain("s5_rekv", 10);
        check("s5_button", button, 8);
        pressed[7] = 1'b0;
        wait_bstate(1'b0, 40, "s5_release");

        // Two-cycle glitch on c2 landing between sample events.
        sync_to_r1("s6_sync");
        tick(2);
        glitch_c2 = 1'b1;
        tick(2);
        glitch_c2 = 1'b0;
        check("s6_row_advanced", {r3, r2, r1}, 3'b101);
        tick(4);
        check("s6_row_next", {r3, r2, r1}, 3'b011);
        tick(20);
        check("s6_bstate", bstate, 1'b0);
        check("s6_button", button, 8);

        drain("final_queue", 10);
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
